// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler.
//   ctrl_state_e        : Ctrl_State encodings (RUN / MULDIV / FREEZE)
//   LOAD_MEMTOREG       : MemToReg_EX value that marks a load in EX
//   DEFAULT_MUL_CYCLES  : default mult/multu HI/LO occupancy
//   DEFAULT_DIV_CYCLES  : default div/divu HI/LO occupancy
//   CNT_W               : occupancy counter width
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'b00,
        CTRL_MULDIV = 2'b01,
        CTRL_FREEZE = 2'b10
    } ctrl_state_e;

    localparam logic [1:0] LOAD_MEMTOREG      = 2'b01;
    localparam int         DEFAULT_MUL_CYCLES = 4;
    localparam int         DEFAULT_DIV_CYCLES = 32;
    localparam int         CNT_W              = 6;

endpackage

// File: rtl/pipeline_stall_controller_muldiv.sv
// muldiv_occupancy_counter: tracks how many more cycles HI/LO is owned by
// an in-flight mult/div.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : mult/div in EX this cycle
//   is_div      : 1 = div/divu, 0 = mult/multu
//   mem_wait    : memory freeze; a start is not accepted while frozen
//   count_next  : value the counter takes at the coming edge
//   busy        : counter currently nonzero
module muldiv_occupancy_counter
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             mem_wait,
    output logic [CNT_W-1:0] count_next,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A start held in EX by a memory freeze is accepted on the first
    // non-wait cycle; the countdown itself keeps running during the freeze.
    // Reload beats decrement if a start ever arrives while busy.
    always_comb begin
        count_d = count_q;
        if (start && !mem_wait) begin
            count_d = is_div ? DIV_LOAD : MUL_LOAD;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_next = count_d;
    assign busy       = (count_q != '0);

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: merges data-memory wait, branch redirect,
// load-use and HI/LO-busy hazards into one set of per-stage controls.
//   Inputs : clk, reset, Rs_ID, Rt_ID, Rt_EX, MemToReg_EX, MulDiv_Start_EX,
//            MulDiv_IsDiv_EX, HiLo_Use_ID, Redirect_EX, Mem_Wait
//   Outputs: Stall_IF, Stall_ID, Flush_ID, Flush_EX, Freeze_Back (combinational),
//            MulDiv_Busy, Ctrl_State (registered state), Stall_Count, Flush_Count
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic [4:0]  Rt_EX,
    input  logic [1:0]  MemToReg_EX,
    input  logic        MulDiv_Start_EX,
    input  logic        MulDiv_IsDiv_EX,
    input  logic        HiLo_Use_ID,
    input  logic        Redirect_EX,
    input  logic        Mem_Wait,
    output logic        Stall_IF,
    output logic        Stall_ID,
    output logic        Flush_ID,
    output logic        Flush_EX,
    output logic        Freeze_Back,
    output logic        MulDiv_Busy,
    output logic [1:0]  Ctrl_State,
    output logic [31:0] Stall_Count,
    output logic [31:0] Flush_Count
);

    logic [CNT_W-1:0] count_next;
    logic             load_use;
    logic             hilo_hazard;
    ctrl_state_e      ctrl_state_q;
    ctrl_state_e      ctrl_state_d;
    logic [31:0]      stall_count_q;
    logic [31:0]      stall_count_d;
    logic [31:0]      flush_count_q;
    logic [31:0]      flush_count_d;

    muldiv_occupancy_counter #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_occupancy (
        .clk        (clk),
        .reset      (reset),
        .start      (MulDiv_Start_EX),
        .is_div     (MulDiv_IsDiv_EX),
        .mem_wait   (Mem_Wait),
        .count_next (count_next),
        .busy       (MulDiv_Busy)
    );

    // $zero is never a real producer, so a load to r0 cannot create a hazard.
    assign load_use    = (MemToReg_EX == LOAD_MEMTOREG) && (Rt_EX != 5'd0) &&
                         ((Rs_ID == Rt_EX) || (Rt_ID == Rt_EX));
    assign hilo_hazard = HiLo_Use_ID && MulDiv_Busy;

    // Strict priority: only the highest active source drives the controls.
    // A redirect squashes the ID instruction, so its hazards are irrelevant.
    always_comb begin
        Stall_IF    = 1'b0;
        Stall_ID    = 1'b0;
        Flush_ID    = 1'b0;
        Flush_EX    = 1'b0;
        Freeze_Back = 1'b0;
        if (Mem_Wait) begin
            Stall_IF    = 1'b1;
            Stall_ID    = 1'b1;
            Freeze_Back = 1'b1;
        end else if (Redirect_EX) begin
            Flush_ID = 1'b1;
            Flush_EX = 1'b1;
        end else if (load_use || hilo_hazard) begin
            Stall_IF = 1'b1;
            Stall_ID = 1'b1;
            Flush_EX = 1'b1;
        end
    end

    always_comb begin
        ctrl_state_d = CTRL_RUN;
        if (Mem_Wait) begin
            ctrl_state_d = CTRL_FREEZE;
        end else if (count_next != '0) begin
            ctrl_state_d = CTRL_MULDIV;
        end
    end

    // Perf counters saturate rather than wrap.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (Stall_IF && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (Flush_ID && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_state_q  <= CTRL_RUN;
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            ctrl_state_q  <= ctrl_state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign Ctrl_State  = ctrl_state_q;
    assign Stall_Count = stall_count_q;
    assign Flush_Count = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed testbench for pipeline_stall_controller with hand-computed
// expected values; one line per failed comparison plus one summary line.
module tb_pipeline_stall_controller;

    logic        clk;
    logic        reset;
    logic [4:0]  Rs_ID, Rt_ID, Rt_EX;
    logic [1:0]  MemToReg_EX;
    logic        MulDiv_Start_EX, MulDiv_IsDiv_EX, HiLo_Use_ID, Redirect_EX, Mem_Wait;
    logic        Stall_IF, Stall_ID, Flush_ID, Flush_EX, Freeze_Back, MulDiv_Busy;
    logic [1:0]  Ctrl_State;
    logic [31:0] Stall_Count, Flush_Count;

    int chk_cnt = 0;
    int err_cnt = 0;

    pipeline_stall_controller #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .Rs_ID           (Rs_ID),
        .Rt_ID           (Rt_ID),
        .Rt_EX           (Rt_EX),
        .MemToReg_EX     (MemToReg_EX),
        .MulDiv_Start_EX (MulDiv_Start_EX),
        .MulDiv_IsDiv_EX (MulDiv_IsDiv_EX),
        .HiLo_Use_ID     (HiLo_Use_ID),
        .Redirect_EX     (Redirect_EX),
        .Mem_Wait        (Mem_Wait),
        .Stall_IF        (Stall_IF),
        .Stall_ID        (Stall_ID),
        .Flush_ID        (Flush_ID),
        .Flush_EX        (Flush_EX),
        .Freeze_Back     (Freeze_Back),
        .MulDiv_Busy     (MulDiv_Busy),
        .Ctrl_State      (Ctrl_State),
        .Stall_Count     (Stall_Count),
        .Flush_Count     (Flush_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs_ID = 5'd0; Rt_ID = 5'd0; Rt_EX = 5'd0; MemToReg_EX = 2'b00;
        MulDiv_Start_EX = 1'b0; MulDiv_IsDiv_EX = 1'b0; HiLo_Use_ID = 1'b0;
        Redirect_EX = 1'b0; Mem_Wait = 1'b0;
    endtask

    // Controls packed as {Stall_IF, Stall_ID, Flush_ID, Flush_EX, Freeze_Back}
    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        check_eq(tag, {27'd0, Stall_IF, Stall_ID, Flush_ID, Flush_EX, Freeze_Back}, {27'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        check_eq("reset_state", {30'd0, Ctrl_State}, 32'd0);
        check_eq("reset_busy", {31'd0, MulDiv_Busy}, 32'd0);
        check_eq("reset_stall_cnt", Stall_Count, 32'd0);
        check_eq("reset_flush_cnt", Flush_Count, 32'd0);
        tick(); tick();
        reset = 1'b0;

        // Load-use on rs: one bubble
        tick();
        MemToReg_EX = 2'b01; Rt_EX = 5'd8; Rs_ID = 5'd8; #1;
        check_ctrl("loaduse_rs", 5'b11010);
        tick();
        clear_inputs(); #1;
        check_ctrl("loaduse_clear", 5'b00000);
        check_eq("loaduse_stall_cnt", Stall_Count, 32'd1);
        // Load to r0 never stalls
        tick();
        MemToReg_EX = 2'b01; Rt_EX = 5'd0; Rs_ID = 5'd0; #1;
        check_ctrl("loaduse_r0", 5'b00000);
        // Load-use on rt
        tick();
        MemToReg_EX = 2'b01; Rt_EX = 5'd9; Rt_ID = 5'd9; Rs_ID = 5'd3; #1;
        check_ctrl("loaduse_rt", 5'b11010);
        // Non-load producer with matching register: no stall
        tick();
        MemToReg_EX = 2'b00; #1;
        check_ctrl("nonload_match", 5'b00000);
        check_eq("loaduse_stall_cnt2", Stall_Count, 32'd2);

        // Divide: start at cycle 0, HI/LO user waits cycles 1..31
        tick();
        clear_inputs(); MulDiv_Start_EX = 1'b1; MulDiv_IsDiv_EX = 1'b1; #1;
        check_ctrl("div_start", 5'b00000);
        check_eq("div_start_busy", {31'd0, MulDiv_Busy}, 32'd0);
        for (int k = 1; k <= 31; k++) begin
            tick();
            MulDiv_Start_EX = 1'b0; MulDiv_IsDiv_EX = 1'b0; HiLo_Use_ID = 1'b1; #1;
            check_ctrl($sformatf("div_stall_c%0d", k), 5'b11010);
            check_eq($sformatf("div_busy_c%0d", k), {31'd0, MulDiv_Busy}, 32'd1);
            check_eq($sformatf("div_state_c%0d", k), {30'd0, Ctrl_State}, 32'd1);
        end
        tick(); #1;
        check_ctrl("div_release", 5'b00000);
        check_eq("div_release_busy", {31'd0, MulDiv_Busy}, 32'd0);
        check_eq("div_release_state", {30'd0, Ctrl_State}, 32'd0);
        check_eq("div_stall_cnt", Stall_Count, 32'd33);

        // Multiply: busy for exactly 3 cycles after start
        tick();
        clear_inputs(); MulDiv_Start_EX = 1'b1; #1;
        check_eq("mul_start_busy", {31'd0, MulDiv_Busy}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            MulDiv_Start_EX = 1'b0; #1;
            check_eq($sformatf("mul_busy_c%0d", k), {31'd0, MulDiv_Busy}, 32'd1);
        end
        tick(); #1;
        check_eq("mul_done_busy", {31'd0, MulDiv_Busy}, 32'd0);

        // Redirect beats load-use
        tick();
        Redirect_EX = 1'b1; MemToReg_EX = 2'b01; Rt_EX = 5'd8; Rs_ID = 5'd8; #1;
        check_ctrl("redirect_over_loaduse", 5'b00110);
        tick();
        clear_inputs(); #1;
        check_eq("redirect_flush_cnt", Flush_Count, 32'd1);
        check_eq("redirect_stall_cnt", Stall_Count, 32'd33);

        // Mem_Wait for 3 cycles over a pending redirect
        for (int k = 1; k <= 3; k++) begin
            tick();
            Redirect_EX = 1'b1; Mem_Wait = 1'b1; #1;
            check_ctrl($sformatf("memwait_c%0d", k), 5'b11001);
            if (k > 1) check_eq($sformatf("memwait_state_c%0d", k), {30'd0, Ctrl_State}, 32'd2);
        end
        tick();
        Mem_Wait = 1'b0; #1;
        check_eq("memwait_state_c4", {30'd0, Ctrl_State}, 32'd2);
        check_ctrl("memwait_release_flush", 5'b00110);
        tick();
        clear_inputs(); #1;
        check_eq("memwait_flush_cnt", Flush_Count, 32'd2);
        check_eq("memwait_stall_cnt", Stall_Count, 32'd36);
        check_eq("memwait_state_after", {30'd0, Ctrl_State}, 32'd0);

        // Reset at divide cycle 10 clears everything without a clock edge
        tick();
        MulDiv_Start_EX = 1'b1; MulDiv_IsDiv_EX = 1'b1; #1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            MulDiv_Start_EX = 1'b0; MulDiv_IsDiv_EX = 1'b0;
        end
        #1;
        check_eq("div10_busy", {31'd0, MulDiv_Busy}, 32'd1);
        check_eq("div10_state", {30'd0, Ctrl_State}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_reset_busy", {31'd0, MulDiv_Busy}, 32'd0);
        check_eq("async_reset_state", {30'd0, Ctrl_State}, 32'd0);
        check_eq("async_reset_stall_cnt", Stall_Count, 32'd0);
        check_eq("async_reset_flush_cnt", Flush_Count, 32'd0);
        tick();
        reset = 1'b0;

        // Saturation of the stall counter
        tick();
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        MemToReg_EX = 2'b01; Rt_EX = 5'd8; Rs_ID = 5'd8; #1;
        check_eq("sat_preload", Stall_Count, 32'hFFFF_FFFE);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("sat_stall_cnt_c%0d", k), Stall_Count, 32'hFFFF_FFFF);
        end
        check_eq("sat_flush_cnt", Flush_Count, 32'd0);
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush scheduler for the 5-stage MIPS pipeline. It sits beside the pipeline registers and merges every stall source into one consistent set of per-stage stall/flush controls:

- data-memory wait;
- taken branch/jump redirect;
- load-use hazard;
- multi-cycle mult/div busy.

It owns the mult/div occupancy counter and two saturating performance counters, and it replaces ad-hoc per-hazard stall wiring.

## Interface
Parameters:
- MUL_CYCLES, 4, total cycles a mult/multu occupies HI/LO (≥1)
- DIV_CYCLES, 32, total cycles a div/divu occupies HI/LO (≥1)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Rs_ID  in  5  rs field of instruction in ID
- Rt_ID  in  5  rt field of instruction in ID
- Rt_EX  in  5  destination rt of instruction in EX
- MemToReg_EX  in  2  2'b01 = load in EX
- MulDiv_Start_EX  in  1  mult/div instruction in EX this cycle
- MulDiv_IsDiv_EX  in  1  1 = div/divu, 0 = mult/multu (valid with Start)
- HiLo_Use_ID  in  1  ID instruction reads HI/LO (mfhi/mflo) or is mult/div/mthi/mtlo
- Redirect_EX  in  1  branch/jump resolved taken in EX
- Mem_Wait  in  1  data memory not ready this cycle
- Stall_IF  out  1  hold PC
- Stall_ID  out  1  hold IF/ID register
- Flush_ID  out  1  clear IF/ID to NOP
- Flush_EX  out  1  clear ID/EX to NOP (bubble)
- Freeze_Back  out  1  hold EX/MEM and MEM/WB
- MulDiv_Busy  out  1  HI/LO occupancy counter nonzero
- Ctrl_State  out  2  00 RUN, 01 MULDIV, 10 FREEZE
- Stall_Count  out  32  cycles with Stall_IF=1
- Flush_Count  out  32  cycles with Flush_ID=1

## Operation
- Outputs are resolved combinationally each cycle in strict priority order; only the highest active source drives outputs.
  1. Mem_Wait=1 → Stall_IF=Stall_ID=Freeze_Back=1, Flush_*=0.
  2. Redirect_EX=1 → Flush_ID=Flush_EX=1, stalls=0. The wrong-path ID instruction is squashed, so any lower hazard on it is ignored.
  3. Load-use: MemToReg_EX==2'b01, Rt_EX≠0 and (Rs_ID==Rt_EX or Rt_ID==Rt_EX) → Stall_IF=Stall_ID=Flush_EX=1.
  4. HI/LO: HiLo_Use_ID=1 and MulDiv_Busy=1 → Stall_IF=Stall_ID=Flush_EX=1.
  5. Otherwise all controls 0.
- Occupancy counter (6 bits, sized for max(DIV_CYCLES, MUL_CYCLES)):
  - Loads DIV_CYCLES−1 or MUL_CYCLES−1 when MulDiv_Start_EX=1 and Mem_Wait=0.
  - Otherwise decrements when nonzero, including during Mem_Wait.
  - MulDiv_Busy = (count≠0).
  - A start while busy cannot occur by construction (priority 4); if it does, reload wins.
- FSM (registered Ctrl_State), next state each edge:
  - FREEZE if Mem_Wait=1;
  - else MULDIV if next count≠0;
  - else RUN.
- Perf counters increment on each edge where Stall_IF=1 or Flush_ID=1 respectively, and saturate at 32'hFFFF_FFFF.

## Timing
- Stall/flush outputs are combinational from inputs and current count. Zero-cycle latency, so the pipeline registers act at the same edge.
- Mult/div start in cycle t: MulDiv_Busy=1 for cycles t+1 … t+N−1. A HI/LO user in ID in cycle t+N proceeds. N=1 never asserts busy.
- Load-use: exactly one bubble per occurrence. In the following cycle the load is in MEM, so the condition clears.
- Redirect and Mem_Wait in the same cycle: Mem_Wait wins. The redirect is held in EX by the freeze and acts on the first non-wait cycle.
- Reset, including mid-operation: count=0, Ctrl_State=RUN, Stall_Count=Flush_Count=0. All combinational outputs then resolve from inputs; MulDiv_Busy=0.

## Structure
- Shared package:
  - Ctrl_State encodings (RUN/MULDIV/FREEZE);
  - LOAD_MEMTOREG = 2'b01;
  - default MUL_CYCLES/DIV_CYCLES.
- One sub-module: muldiv_occupancy_counter (load/decrement/busy).
- Priority resolve, FSM and perf counters stay in the top.

## Test plan
- Load-use: MemToReg_EX=01, Rt_EX=8, Rs_ID=8 → one cycle Stall_IF=Stall_ID=Flush_EX=1. With Rt_EX=0 → no stall.
- Divide: MulDiv_Start_EX=1, IsDiv=1 at cycle 0, HiLo_Use_ID=1 from cycle 1 → stall cycles 1–31, release at cycle 32, Stall_Count=31, Ctrl_State=01 during stall.
- Redirect_EX=1 together with a load-use match → Flush_ID=Flush_EX=1, Stall_IF=0, Flush_Count+1.
- Mem_Wait=1 for 3 cycles during a redirect → Freeze_Back=1 and Ctrl_State=10 for 3 cycles, then Flush_ID=1 on cycle 4.
- Reset asserted at divide cycle 10 → MulDiv_Busy=0 and counters=0 immediately, without a clock edge.
- Force Stall_Count to 32'hFFFF_FFFE, then 3 stall cycles → holds at 32'hFFFF_FFFF.
